// File: rtl/afe_seq_pkg.sv
// Shared opcodes, state encoding and error codes for the AFE sequence controller.
package afe_seq_pkg;

  localparam logic [3:0] OP_DONE   = 4'd0;
  localparam logic [3:0] OP_SEND   = 4'd1;
  localparam logic [3:0] OP_DELAY  = 4'd2;
  localparam logic [3:0] OP_SETCNT = 4'd3;
  localparam logic [3:0] OP_LOOP   = 4'd4;

  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_BAD_OPCODE = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT    = 2'd2;
  localparam logic [1:0] ERR_ABORT      = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_WAIT_READY,
    ST_TRIGGER,
    ST_HOLD,
    ST_DELAY,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } state_t;

  function automatic logic is_busy(input state_t s);
    return !(s inside {ST_IDLE, ST_DONE, ST_ERROR});
  endfunction

endpackage

// File: rtl/afe_seq_timer.sv
// Loadable down-counter with a zero flag; decrement saturates at zero.
module afe_seq_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/afe_sequence_controller.sv
// Walks the AFE command ROM and drives the serial shifter: sends, delays,
// counted loops, ready timeout and abort. All outputs are registered.
module afe_sequence_controller
  import afe_seq_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int PAYLOAD_WIDTH  = 24,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       abort,
  output logic [ADDR_WIDTH-1:0]      rom_address,
  input  logic [PAYLOAD_WIDTH+3:0]   rom_data,
  input  logic                       serial_ready,
  output logic [PAYLOAD_WIDTH-1:0]   serial_data,
  output logic                       start_transaction,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [1:0]                 error_code
);

  localparam int TO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_WIDTH-1:0] TO_LOAD = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    addr_d;
  logic [PAYLOAD_WIDTH-1:0] serial_d;
  logic [PAYLOAD_WIDTH-1:0] pending_q, pending_d;
  logic [CNT_WIDTH-1:0]     loop_cnt, loop_d;
  logic [1:0]               code_d;

  logic [3:0]               opcode;
  logic [PAYLOAD_WIDTH-1:0] operand;
  logic [CNT_WIDTH-1:0]     operand_cnt;
  logic [CNT_WIDTH-1:0]     delay_value;

  logic delay_load, delay_dec, delay_zero;
  logic to_load, to_dec, to_zero;

  assign opcode      = rom_data[PAYLOAD_WIDTH +: 4];
  assign operand     = rom_data[PAYLOAD_WIDTH-1:0];
  assign operand_cnt = operand[CNT_WIDTH-1:0];
  assign delay_value = operand_cnt - CNT_WIDTH'(1);

  afe_seq_timer #(.WIDTH(CNT_WIDTH)) u_delay_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (delay_load),
    .load_value (delay_value),
    .dec        (delay_dec),
    .zero       (delay_zero)
  );

  afe_seq_timer #(.WIDTH(TO_WIDTH)) u_timeout_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (to_load),
    .load_value (TO_LOAD),
    .dec        (to_dec),
    .zero       (to_zero)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = rom_address;
    serial_d   = serial_data;
    pending_d  = pending_q;
    loop_d     = loop_cnt;
    code_d     = error_code;
    delay_load = 1'b0;
    delay_dec  = 1'b0;
    to_load    = 1'b0;
    to_dec     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_FETCH;
          addr_d  = '0;
        end
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_SEND: begin
            pending_d = operand;
            to_load   = 1'b1;
            state_d   = ST_WAIT_READY;
          end
          OP_DELAY: begin
            if (operand_cnt == '0) begin
              state_d = ST_NEXT;
            end else begin
              delay_load = 1'b1;
              state_d    = ST_DELAY;
            end
          end
          OP_SETCNT: begin
            loop_d  = operand_cnt;
            state_d = ST_NEXT;
          end
          OP_LOOP: begin
            if (loop_cnt != '0) begin
              loop_d  = loop_cnt - CNT_WIDTH'(1);
              addr_d  = operand[ADDR_WIDTH-1:0];
              state_d = ST_FETCH;
            end else begin
              state_d = ST_NEXT;
            end
          end
          OP_DONE: state_d = ST_DONE;
          default: begin
            state_d = ST_ERROR;
            code_d  = ERR_BAD_OPCODE;
          end
        endcase
      end
      ST_WAIT_READY: begin
        if (serial_ready) begin
          state_d  = ST_TRIGGER;
          serial_d = pending_q;
        end else if (to_zero) begin
          state_d = ST_ERROR;
          code_d  = ERR_TIMEOUT;
        end else begin
          to_dec = 1'b1;
        end
      end
      ST_TRIGGER: state_d = ST_HOLD;
      ST_HOLD:    state_d = ST_NEXT;
      ST_DELAY: begin
        if (delay_zero) state_d = ST_NEXT;
        else            delay_dec = 1'b1;
      end
      ST_NEXT: begin
        if (&rom_address) begin
          state_d = ST_ERROR;
          code_d  = ERR_ABORT;
        end else begin
          addr_d  = rom_address + ADDR_WIDTH'(1);
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        if (!enable) state_d = ST_IDLE;
      end
      ST_ERROR: begin
        if (!enable) begin
          state_d = ST_IDLE;
          code_d  = ERR_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort beats every other transition and cancels its side effects.
    if (abort && is_busy(state_q)) begin
      state_d  = ST_ERROR;
      code_d   = ERR_ABORT;
      addr_d   = rom_address;
      serial_d = serial_data;
      loop_d   = loop_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      rom_address       <= '0;
      serial_data       <= '0;
      pending_q         <= '0;
      loop_cnt          <= '0;
      start_transaction <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      error             <= 1'b0;
      error_code        <= ERR_NONE;
    end else begin
      state_q           <= state_d;
      rom_address       <= addr_d;
      serial_data       <= serial_d;
      pending_q         <= pending_d;
      loop_cnt          <= loop_d;
      start_transaction <= (state_d == ST_TRIGGER);
      busy              <= is_busy(state_d);
      done              <= (state_d == ST_DONE);
      error             <= (state_d == ST_ERROR);
      error_code        <= code_d;
    end
  end

endmodule

// File: tb/tb_afe_sequence_controller.sv
// Self-checking bench: directed cycle-exact vectors, hand-written abort/reset/overflow
// sequences, and random programs against an instruction-level reference model.
module tb_afe_sequence_controller;

  localparam logic [3:0] OPC_DONE = 4'd0, OPC_SEND = 4'd1, OPC_DELAY = 4'd2,
                         OPC_SETCNT = 4'd3, OPC_LOOP = 4'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        abort = 1'b0;
  logic        serial_ready = 1'b0;
  logic [7:0]  rom_address;
  logic [27:0] rom_data;
  logic [23:0] serial_data;
  logic        start_transaction, busy, done, error;
  logic [1:0]  error_code;

  logic        enable2 = 1'b0;
  logic [1:0]  rom_address2;
  logic [23:0] serial_data2;
  logic        start2, busy2, done2, error2;
  logic [1:0]  code2;

  logic [27:0] rom [256];
  logic [23:0] gotQ[$];
  logic [23:0] expQ[$];
  int          readyMode = 0;
  int          modelLoop = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [3:0][27:0] prog;
    int               readyMode;
    int               nStrobe;
    logic [23:0]      firstData;
    logic [23:0]      lastData;
    logic             expDone;
    logic [1:0]       expCode;
    int               firstStrobe;
    int               endCycle;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_address];

  always @(negedge clk)
    serial_ready = (readyMode == 2) ? ($urandom_range(0, 3) != 0) : (readyMode == 1);

  afe_sequence_controller dut (
    .clk(clk), .reset(reset), .enable(enable), .abort(abort),
    .rom_address(rom_address), .rom_data(rom_data), .serial_ready(serial_ready),
    .serial_data(serial_data), .start_transaction(start_transaction),
    .busy(busy), .done(done), .error(error), .error_code(error_code)
  );

  afe_sequence_controller #(.ADDR_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable2), .abort(1'b0),
    .rom_address(rom_address2), .rom_data({OPC_DELAY, 24'd1}), .serial_ready(1'b1),
    .serial_data(serial_data2), .start_transaction(start2),
    .busy(busy2), .done(done2), .error(error2), .error_code(code2)
  );

  function automatic logic [27:0] wd(input logic [3:0] op, input logic [23:0] opd);
    return {op, opd};
  endfunction

  function automatic vec_t mkVec(input logic [27:0] w0, w1, w2, w3, input int mode, nStr,
                                 input logic [23:0] firstD, lastD, input logic dn,
                                 input logic [1:0] code, input int firstS, endC);
    vec_t v;
    v.prog[0] = w0; v.prog[1] = w1; v.prog[2] = w2; v.prog[3] = w3;
    v.readyMode = mode; v.nStrobe = nStr; v.firstData = firstD; v.lastData = lastD;
    v.expDone = dn; v.expCode = code; v.firstStrobe = firstS; v.endCycle = endC;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic doReset();
    reset = 1'b1; enable = 1'b0; enable2 = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    modelLoop = 0;
  endtask

  task automatic clearRom();
    for (int i = 0; i < 256; i++) rom[i] = 28'd0;
  endtask

  // Cycle t=0 is the first cycle after the edge that sees enable high.
  task automatic runProgram(input int maxCycles, input int abortAt,
                            output int endCycle, output int firstStrobe);
    endCycle = -1;
    firstStrobe = -1;
    gotQ.delete();
    for (int t = 0; t < maxCycles; t++) begin
      @(posedge clk); #1;
      if (t == 0) begin
        checkOutput("start_busy", busy, 1);
        checkOutput("start_address", rom_address, 0);
      end
      if (start_transaction) begin
        gotQ.push_back(serial_data);
        if (firstStrobe < 0) firstStrobe = t;
      end
      if (done || error) begin
        endCycle = t;
        abort = 1'b0;
        break;
      end
      abort = (t == abortAt);
    end
    abort = 1'b0;
    if (endCycle < 0) checkOutput("run_bound_expired", 0, 1);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int endC, firstS;
    string tag;
    doReset();
    clearRom();
    for (int i = 0; i < 4; i++) rom[i] = v.prog[i];
    readyMode = v.readyMode;
    enable = 1'b1;
    runProgram(5000, -1, endC, firstS);
    tag = $sformatf("vec%0d", idx);
    checkOutput({tag, "_strobes"}, gotQ.size(), v.nStrobe);
    if (v.nStrobe > 0)
      checkOutput({tag, "_first_data"}, (gotQ.size() > 0) ? {8'd0, gotQ[0]} : 32'hDEADBEEF,
                  v.firstData);
    checkOutput({tag, "_serial_data"}, serial_data, v.lastData);
    checkOutput({tag, "_first_strobe"}, firstS, v.firstStrobe);
    checkOutput({tag, "_end_cycle"}, endC, v.endCycle);
    checkOutput({tag, "_done"}, done, v.expDone);
    checkOutput({tag, "_error"}, error, !v.expDone);
    checkOutput({tag, "_code"}, error_code, v.expCode);
    checkOutput({tag, "_busy_end"}, busy, 0);
    enable = 1'b0;
  endtask

  function automatic logic [27:0] randItem();
    if ($urandom_range(0, 1) == 1) return {OPC_SEND, 24'($urandom)};
    return {OPC_DELAY, 8'($urandom), 16'($urandom_range(0, 5))};
  endfunction

  task automatic genProgram();
    int idx = 0;
    int body;
    clearRom();
    repeat ($urandom_range(0, 2)) begin rom[idx] = randItem(); idx++; end
    rom[idx] = {OPC_SETCNT, 8'($urandom), 16'($urandom_range(0, 3))}; idx++;
    body = idx;
    repeat ($urandom_range(1, 2)) begin rom[idx] = randItem(); idx++; end
    rom[idx] = {OPC_LOOP, 16'($urandom), 8'(body)}; idx++;
    repeat ($urandom_range(0, 1)) begin rom[idx] = randItem(); idx++; end
    rom[idx] = ($urandom_range(0, 4) == 0) ? {4'($urandom_range(5, 15)), 24'($urandom)}
                                           : {OPC_DONE, 24'($urandom)};
  endtask

  // Instruction-level interpreter: what gets sent and how the program ends.
  task automatic modelRun(output logic expDone, output logic [1:0] expCode);
    int pc = 0;
    logic [27:0] w;
    expQ.delete();
    expDone = 1'b0;
    expCode = 2'd0;
    for (int step = 0; step < 2000; step++) begin
      w = rom[pc];
      case (w[27:24])
        OPC_DONE:   begin expDone = 1'b1; return; end
        OPC_SEND:   expQ.push_back(w[23:0]);
        OPC_DELAY:  ;
        OPC_SETCNT: modelLoop = int'(w[15:0]);
        OPC_LOOP: begin
          if (modelLoop != 0) begin
            modelLoop--;
            pc = int'(w[7:0]);
            continue;
          end
        end
        default:    begin expCode = 2'd1; return; end
      endcase
      if (pc == 255) begin expCode = 2'd3; return; end
      pc++;
    end
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int endC, firstS, t2;
    logic expDone;
    logic [1:0] expCode;

    vecs[0] = mkVec(wd(OPC_SEND, 24'h123456), wd(OPC_SEND, 24'h00ABCD), wd(OPC_DONE, 0), 0,
                    1, 2, 24'h123456, 24'h00ABCD, 1, 0, 3, 14);
    vecs[1] = mkVec(wd(OPC_DELAY, 24'd10), wd(OPC_SEND, 24'd1), wd(OPC_DONE, 0), 0,
                    1, 1, 24'd1, 24'd1, 1, 0, 16, 21);
    vecs[2] = mkVec(wd(OPC_DELAY, 24'd0), wd(OPC_SEND, 24'd1), wd(OPC_DONE, 0), 0,
                    1, 1, 24'd1, 24'd1, 1, 0, 6, 11);
    vecs[3] = mkVec(wd(OPC_SETCNT, 24'd3), wd(OPC_SEND, 24'h55), wd(OPC_LOOP, 24'd1),
                    wd(OPC_DONE, 0), 1, 4, 24'h55, 24'h55, 1, 0, 6, 38);
    vecs[4] = mkVec(wd(4'd7, 24'd0), 0, 0, 0, 1, 0, 0, 0, 0, 1, -1, 2);
    vecs[5] = mkVec(wd(OPC_SEND, 24'hC0FFEE), wd(4'hF, 24'h123), 0, 0,
                    1, 1, 24'hC0FFEE, 24'hC0FFEE, 0, 1, 3, 8);
    vecs[6] = mkVec(wd(OPC_DELAY, 24'hFF0003), wd(OPC_SEND, 24'd2), wd(OPC_DONE, 0), 0,
                    1, 1, 24'd2, 24'd2, 1, 0, 9, 14);
    vecs[7] = mkVec(wd(OPC_SEND, 24'hAAAAAA), wd(OPC_DONE, 0), 0, 0,
                    0, 0, 0, 24'd0, 0, 2, -1, 4098);
    vecs[8] = mkVec(wd(OPC_SETCNT, 24'hAB0001), wd(OPC_SEND, 24'h11), wd(OPC_LOOP, 24'hFFFF01),
                    wd(OPC_DONE, 0), 1, 2, 24'h11, 24'h11, 1, 0, 6, 22);

    doReset();
    @(posedge clk); #1;
    checkOutput("reset_addr_data", {rom_address, serial_data}, 0);
    checkOutput("reset_flags", {start_transaction, busy, done, error, error_code}, 0);

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);

    $display("[TB] abort during DELAY, then enable low and re-enable");
    doReset();
    clearRom();
    rom[0] = wd(OPC_DELAY, 24'd100);
    rom[1] = wd(OPC_SEND, 24'h77);
    rom[2] = wd(OPC_DONE, 0);
    readyMode = 1;
    enable = 1'b1;
    runProgram(300, 20, endC, firstS);
    checkOutput("abort_delay_cycle", endC, 21);
    checkOutput("abort_delay_error", error, 1);
    checkOutput("abort_delay_code", error_code, 3);
    checkOutput("abort_delay_strobes", gotQ.size(), 0);
    enable = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_after_error", {busy, done, error, error_code}, 0);
    enable = 1'b1;
    runProgram(300, -1, endC, firstS);
    checkOutput("reenable_end_cycle", endC, 111);
    checkOutput("reenable_strobe_cycle", firstS, 106);
    checkOutput("reenable_data", serial_data, 24'h77);
    checkOutput("reenable_done", done, 1);
    enable = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_after_done", {busy, done, error}, 0);

    $display("[TB] abort while ready is high suppresses strobe");
    doReset();
    clearRom();
    rom[0] = wd(OPC_SEND, 24'h123456);
    rom[1] = wd(OPC_DONE, 0);
    readyMode = 1;
    enable = 1'b1;
    runProgram(50, 2, endC, firstS);
    checkOutput("abort_wait_cycle", endC, 3);
    checkOutput("abort_wait_strobes", gotQ.size(), 0);
    checkOutput("abort_wait_code", error_code, 3);
    checkOutput("abort_wait_serial", serial_data, 0);

    $display("[TB] reset mid-SEND");
    doReset();
    enable = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("pre_reset_strobe", start_transaction, 1);
    checkOutput("pre_reset_data", serial_data, 24'h123456);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("mid_reset_addr_data", {rom_address, serial_data}, 0);
    checkOutput("mid_reset_flags", {start_transaction, busy, done, error, error_code}, 0);
    reset = 1'b0;
    enable = 1'b0;

    $display("[TB] address overflow with ADDR_WIDTH=2");
    doReset();
    enable2 = 1'b1;
    t2 = -1;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); #1;
      if (error2) begin t2 = t; break; end
    end
    checkOutput("overflow_cycle", t2, 16);
    checkOutput("overflow_code", code2, 3);
    checkOutput("overflow_address", rom_address2, 3);
    checkOutput("overflow_flags", {busy2, done2, start2, serial_data2}, 0);
    enable2 = 1'b0;

    $display("[TB] random programs against reference model");
    doReset();
    for (int r = 0; r < 25; r++) begin
      enable = 1'b0;
      @(posedge clk); #1;
      genProgram();
      modelRun(expDone, expCode);
      readyMode = 2;
      enable = 1'b1;
      runProgram(3000, -1, endC, firstS);
      checkOutput("rand_strobe_count", gotQ.size(), expQ.size());
      for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
        checkOutput("rand_payload", gotQ[i], expQ[i]);
      checkOutput("rand_done", done, expDone);
      checkOutput("rand_code", error_code, expCode);
    end
    enable = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
